result_bcd_conv: RTL

- Downstream consumer of the iterative function FSM's result port (signed 15-bit `out` plus level `valid`).
- On each rising edge of `valid`, captures the result and converts it to sign plus 5-digit BCD magnitude with a sequential shift-add-3 (double-dabble) engine.
- Presents the result registered, with a one-cycle completion pulse.
- Optionally drives a multiplexed 6-digit seven-segment display (sign plus 5 digits) for the board demo.

---
 rtl/func_pkg.sv | 43 ++++
 rtl/result_bcd_conv_if.sv | 19 +
 rtl/result_bcd_conv_seg_decoder.sv | 33 +++
 rtl/result_bcd_conv.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/func_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// func_pkg: shared widths, converter state encoding and seven-segment glyphs.
// Rev 1.0
// ---------------------------------------------------------------------------
package func_pkg;

   localparam int Y_W        = 15;
   localparam int BCD_DIGITS = 5;
   localparam int BCD_W      = 4 * BCD_DIGITS;
   localparam int CNT_W      = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } conv_state_t;

   // Active-low glyphs, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_MINUS = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] s);
      logic [BCD_W-1:0] r;
      r = s;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/result_bcd_conv_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// result_bcd_conv_if: result input and BCD output bundle of the converter.
// Rev 1.0
// ---------------------------------------------------------------------------
interface result_bcd_conv_if;

   logic signed [func_pkg::Y_W-1:0]   y_in;
   logic                              y_valid;
   logic                              busy;
   logic                              done;
   logic                              sign;
   logic        [func_pkg::BCD_W-1:0] bcd;

   modport master (output y_in, y_valid, input busy, done, sign, bcd);
   modport slave  (input y_in, y_valid, output busy, done, sign, bcd);

endinterface
`default_nettype wire

// File: rtl/result_bcd_conv_seg_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_seg_decoder: BCD nibble to active-low glyph; only built with SEG_SCAN_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`ifdef SEG_SCAN_EN
module bcd_seg_decoder
   import func_pkg::*;
(
   input  wire logic [3:0] nibble,
   output logic      [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (nibble)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule
`endif
`default_nettype wire

// File: rtl/result_bcd_conv.sv
`default_nettype none
// ---------------------------------------------------------------------------
// result_bcd_conv: signed result to sign + 5-digit BCD by double-dabble.
// SEG_SCAN_EN adds a multiplexed 6-digit seven-segment driver. Rev 1.0
// ---------------------------------------------------------------------------
module result_bcd_conv
   import func_pkg::*;
`ifdef SEG_SCAN_EN
   #(parameter int SCAN_PERIOD = 100000)
`endif
(
   input  wire logic        clk,
   input  wire logic        rst,
   result_bcd_conv_if.slave bus
`ifdef SEG_SCAN_EN
   ,
   output logic      [6:0]  seg,
   output logic      [5:0]  an
`endif
);

   conv_state_t            state, state_next;
   logic                   y_prev;
   logic                   start;
   logic                   load;
   logic                   shifting;
   logic                   publish;
   logic                   sgn_r;
   logic       [Y_W-1:0]   mag;
   logic       [Y_W-1:0]   mag_in;
   logic       [BCD_W-1:0] scratch;
   logic       [BCD_W-1:0] scratch_adj;
   logic       [CNT_W-1:0] cnt;
   logic                   busy_r;
   logic                   done_r;
   logic                   sign_r;
   logic       [BCD_W-1:0] bcd_r;

   assign start       = bus.y_valid & ~y_prev;
   assign scratch_adj = dabble_adjust(scratch);
   // Two's-complement negate in 15 bits: -16384 maps to 16384 as unsigned
   assign mag_in      = bus.y_in[Y_W-1] ? (~bus.y_in + 1'b1) : bus.y_in;

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      shifting   = 1'b0;
      publish    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            shifting = 1'b1;
            if (cnt == CNT_W'(1)) state_next = DONE;
         end
         DONE: begin
            publish    = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         y_prev  <= 1'b0;
         sgn_r   <= 1'b0;
         mag     <= '0;
         scratch <= '0;
         cnt     <= '0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         sign_r  <= 1'b0;
         bcd_r   <= '0;
      end else begin
         y_prev <= bus.y_valid;
         done_r <= publish;
         if (load) begin
            sgn_r   <= bus.y_in[Y_W-1];
            mag     <= mag_in;
            scratch <= '0;
            cnt     <= CNT_W'(Y_W);
         end else if (shifting) begin
            {scratch, mag} <= {scratch_adj[BCD_W-2:0], mag, 1'b0};
            cnt            <= cnt - 1'b1;
         end
         if (publish) begin
            bcd_r  <= scratch;
            sign_r <= sgn_r;
         end
         // Busy spans the completion pulse so it covers all 17 cycles
         if (load)        busy_r <= 1'b1;
         else if (done_r) busy_r <= 1'b0;
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.sign = sign_r;
   assign bus.bcd  = bcd_r;

`ifdef SEG_SCAN_EN
   localparam int             SCAN_W    = $clog2(SCAN_PERIOD);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_PERIOD - 1);

   logic [SCAN_W-1:0] scan_cnt;
   logic [2:0]        digit;
   logic [3:0]        nibble;
   logic [6:0]        glyph;

   always_comb begin
      nibble = 4'd0;
      case (digit)
         3'd0:    nibble = bcd_r[3:0];
         3'd1:    nibble = bcd_r[7:4];
         3'd2:    nibble = bcd_r[11:8];
         3'd3:    nibble = bcd_r[15:12];
         3'd4:    nibble = bcd_r[19:16];
         default: nibble = 4'd0;
      endcase
   end

   bcd_seg_decoder u_dec (
      .nibble (nibble),
      .seg    (glyph)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         scan_cnt <= '0;
         digit    <= 3'd0;
         seg      <= SEG_BLANK;
         an       <= 6'h3F;
      end else begin
         if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            digit    <= (digit == 3'd5) ? 3'd0 : digit + 3'd1;
         end else begin
            scan_cnt <= scan_cnt + 1'b1;
         end
         an  <= ~(6'b000001 << digit);
         seg <= (digit == 3'd5) ? (sign_r ? SEG_MINUS : SEG_BLANK) : glyph;
      end
   end
`endif

endmodule
`default_nettype wire
